// File: rtl/sec_an_pkg.sv
// Shared constants, FSM states and the syndrome-to-correction mapping for the
// AN-code single-error-correcting decoder.
package sec_an_pkg;

  localparam int A_DEF  = 1939;
  localparam int WW_DEF = 19;
  localparam int NW_DEF = 8;
  localparam int SW     = $clog2(WW_DEF + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV1,
    ST_CHECK,
    ST_DIV2,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic          hit;
    logic          neg;
    logic [SW-1:0] shift;
  } delta_t;

  // Walks 2^i mod a instead of storing a table, so any odd code constant works.
  function automatic delta_t syn_to_delta(input int r, input int a, input int ww);
    delta_t res;
    int     p;
    res = '0;
    p   = 1 % a;
    for (int i = 0; i <= ww; i++) begin
      if (!res.hit && r != 0) begin
        if (r == p) begin
          res.hit   = 1'b1;
          res.neg   = 1'b0;
          res.shift = SW'(i);
        end else if (r == a - p) begin
          res.hit   = 1'b1;
          res.neg   = 1'b1;
          res.shift = SW'(i);
        end
      end
      p = (p * 2) % a;
    end
    return res;
  endfunction

endpackage

// File: rtl/an_serial_div.sv
// Restoring serial divider by the constant A: one quotient bit per clock, MSB
// first, D steps per division. load+start together take the first step on the
// incoming dividend, so busy is already low in the cycle the results are final.
module an_serial_div #(
  parameter int D = 20,
  parameter int A = 1939
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [D-1:0]         dividend,
  input  logic                 start,
  output logic                 busy,
  output logic [D-1:0]         quotient,
  output logic [$clog2(A)-1:0] remainder
);

  localparam int AW = $clog2(A);
  localparam int CW = $clog2(D);
  localparam logic [AW:0] A_EXT = (AW+1)'(A);

  logic [D-1:0]  quo_q, quo_d, src_quo;
  logic [AW-1:0] rem_q, rem_d, src_rem, step_rem;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d, step_bit;
  logic [AW:0]   trial;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    src_quo = load ? dividend : quo_q;
    src_rem = load ? '0 : rem_q;
    trial   = {src_rem, src_quo[D-1]};
    if (trial >= A_EXT) begin
      step_rem = AW'(trial - A_EXT);
      step_bit = 1'b1;
    end else begin
      step_rem = trial[AW-1:0];
      step_bit = 1'b0;
    end
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
    end
    // Dividend bits leave at the top of quo while quotient bits enter at the bottom.
    if (start || run_q) begin
      quo_d = {src_quo[D-2:0], step_bit};
      rem_d = step_rem;
    end
    if (start) begin
      cnt_d = CW'(D - 2);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign busy      = run_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/sec_an_decode_ctrl.sv
// Sequencer for AN-code single-error correction: divide, look up the syndrome,
// optionally re-divide the corrected word, and hand N out with status flags.
module sec_an_decode_ctrl
  import sec_an_pkg::*;
#(
  parameter int A  = A_DEF,
  parameter int WW = WW_DEF,
  parameter int NW = NW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WW-1:0] in_w,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_n,
  output logic          out_corrected,
  output logic          out_uncorr,
  output logic          out_overflow,
  output logic [15:0]   corr_count
);

  localparam int D  = WW + 1;
  localparam int AW = $clog2(A);

  state_e        state_q, state_d;
  logic [D-1:0]  w_q, w_d;
  logic [NW-1:0] n_q, n_d;
  logic          corrected_q, corrected_d;
  logic          uncorr_q, uncorr_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   corr_cnt_q, corr_cnt_d;

  logic          div_load, div_start, div_busy;
  logic [D-1:0]  div_dividend, div_quo;
  logic [AW-1:0] div_rem;
  delta_t        syn;
  logic [D:0]    delta_mag, w_minus_delta;

  an_serial_div #(.D(D), .A(A)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (div_load),
    .dividend  (div_dividend),
    .start     (div_start),
    .busy      (div_busy),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d       = state_q;
    w_d           = w_q;
    n_d           = n_q;
    corrected_d   = corrected_q;
    uncorr_d      = uncorr_q;
    overflow_d    = overflow_q;
    corr_cnt_d    = corr_cnt_q;
    div_load      = 1'b0;
    div_start     = 1'b0;
    div_dividend  = w_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    syn           = syn_to_delta(int'(div_rem), A, WW);
    delta_mag     = (D+1)'(1) << syn.shift;
    // One extra bit so a correction that would drive the word below zero is visible.
    w_minus_delta = syn.neg ? ({1'b0, w_q} + delta_mag) : ({1'b0, w_q} - delta_mag);

    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_d          = D'(in_w);
          div_dividend = D'(in_w);
          div_load     = 1'b1;
          div_start    = 1'b1;
          state_d      = ST_DIV1;
        end
      end
      ST_DIV1: begin
        if (!div_busy) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (div_rem != '0 && syn.hit && !w_minus_delta[D]) begin
          div_dividend = w_minus_delta[D-1:0];
          div_load     = 1'b1;
          div_start    = 1'b1;
          state_d      = ST_DIV2;
        end else begin
          n_d         = div_quo[NW-1:0];
          overflow_d  = |div_quo[D-1:NW];
          corrected_d = 1'b0;
          uncorr_d    = (div_rem != '0);
          state_d     = ST_DONE;
        end
      end
      ST_DIV2: begin
        if (!div_busy) begin
          n_d         = div_quo[NW-1:0];
          overflow_d  = |div_quo[D-1:NW];
          corrected_d = 1'b1;
          uncorr_d    = 1'b0;
          if (corr_cnt_q != 16'hFFFF) corr_cnt_d = corr_cnt_q + 16'd1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      n_q         <= '0;
      corrected_q <= 1'b0;
      uncorr_q    <= 1'b0;
      overflow_q  <= 1'b0;
      corr_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      n_q         <= n_d;
      corrected_q <= corrected_d;
      uncorr_q    <= uncorr_d;
      overflow_q  <= overflow_d;
      corr_cnt_q  <= corr_cnt_d;
    end
  end

  assign out_n         = n_q;
  assign out_corrected = corrected_q;
  assign out_uncorr    = uncorr_q;
  assign out_overflow  = overflow_q;
  assign corr_count    = corr_cnt_q;

endmodule

// File: tb/tb_sec_an_decode_ctrl.sv
// Self-checking bench for sec_an_decode_ctrl: directed cases, backpressure,
// reset during the second division, and randomized traffic against a model.
module tb_sec_an_decode_ctrl;

  localparam int A  = 1939;
  localparam int WW = 19;
  localparam int NW = 8;

  typedef struct {
    int w;
    int n;
    int corr;
    int unc;
    int ovf;
    int lat;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WW-1:0] in_w;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_n;
  logic          out_corrected;
  logic          out_uncorr;
  logic          out_overflow;
  logic [15:0]   corr_count;

  int n_cmp     = 0;
  int n_fail    = 0;
  int model_cnt = 0;

  sec_an_decode_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_w          (in_w),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_n         (out_n),
    .out_corrected (out_corrected),
    .out_uncorr    (out_uncorr),
    .out_overflow  (out_overflow),
    .corr_count    (corr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decoder built from plain integer arithmetic on 2^i.
  function automatic void model(input longint w, output int n, output int corr,
                                output int unc, output int ovf);
    longint q, r, v, delta, p;
    bit     found;
    q = w / A;
    r = w % A;
    corr = 0;
    unc  = 0;
    if (r != 0) begin
      found = 0;
      delta = 0;
      for (int i = 0; i <= WW; i++) begin
        p = (longint'(1) << i) % A;
        if (!found && r == p) begin
          found = 1;
          delta = longint'(1) << i;
        end else if (!found && r == A - p) begin
          found = 1;
          delta = -(longint'(1) << i);
        end
      end
      if (!found) unc = 1;
      else begin
        v = w - delta;
        if (v < 0) unc = 1;
        else begin
          corr = 1;
          q = v / A;
        end
      end
    end
    ovf = (q > 255) ? 1 : 0;
    n   = int'(q % 256);
  endfunction

  // Presents one word, then counts edges until out_valid (bounded).
  task automatic send_word(input int w, output int cycles, output bit ok);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_w     = WW'(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_w     = WW'($urandom);
    cycles   = 0;
    while (out_valid !== 1'b1 && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_handshake: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    n_cmp++;
    if (out_n !== 8'd0 || out_corrected !== 1'b0 || out_uncorr !== 1'b0 || out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got n=%0d c=%b u=%b o=%b expected all 0", out_n, out_corrected, out_uncorr, out_overflow);
    end
    n_cmp++;
    if (corr_count !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_count: got %0d expected 0", corr_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t vecs[9];
    int   cycles;
    bit   ok;
    vecs = '{
      '{387800, 200, 0, 0, 0, 21},
      '{389848, 200, 1, 0, 0, 41},
      '{387799, 200, 1, 0, 0, 41},
      '{387803, 200, 0, 1, 0, 21},
      '{504140,   4, 0, 0, 1, 21},
      '{   109,   0, 0, 1, 0, 21},
      '{524287,  14, 0, 1, 1, 21},
      '{456044, 100, 1, 0, 0, 41},
      '{     0,   0, 0, 0, 0, 21}
    };
    foreach (vecs[k]) begin
      send_word(vecs[k].w, cycles, ok);
      n_cmp++;
      if (!ok || cycles != vecs[k].lat) begin
        n_fail++;
        $display("[TB] FAIL dir_latency w=%0d: got %0d cycles expected %0d", vecs[k].w, cycles, vecs[k].lat);
      end
      n_cmp++;
      if (out_n !== NW'(vecs[k].n)) begin
        n_fail++;
        $display("[TB] FAIL dir_n w=%0d: got %0d expected %0d", vecs[k].w, out_n, vecs[k].n);
      end
      n_cmp++;
      if (out_corrected !== vecs[k].corr[0] || out_uncorr !== vecs[k].unc[0] || out_overflow !== vecs[k].ovf[0]) begin
        n_fail++;
        $display("[TB] FAIL dir_flags w=%0d: got c=%b u=%b o=%b expected c=%0d u=%0d o=%0d",
                 vecs[k].w, out_corrected, out_uncorr, out_overflow, vecs[k].corr, vecs[k].unc, vecs[k].ovf);
      end
      if (vecs[k].corr != 0) model_cnt++;
      n_cmp++;
      if (corr_count !== 16'(model_cnt)) begin
        n_fail++;
        $display("[TB] FAIL dir_count w=%0d: got %0d expected %0d", vecs[k].w, corr_count, model_cnt);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_n !== NW'(vecs[k].n)) begin
        n_fail++;
        $display("[TB] FAIL dir_handoff w=%0d: got valid=%b ready=%b n=%0d expected 0/1/%0d",
                 vecs[k].w, out_valid, in_ready, out_n, vecs[k].n);
      end
    end
  endtask

  task automatic test_backpressure();
    int  cycles;
    bit  ok;
    bool_seen_t: begin end
    send_word(389848, cycles, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("[TB] FAIL bp_valid: got no out_valid within %0d cycles expected 41", cycles);
    end
    model_cnt++;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_w     = WW'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_n !== 8'd200 || out_corrected !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b ready=%b n=%0d c=%b expected 1/0/200/1",
                 c, out_valid, in_ready, out_n, out_corrected);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_n !== 8'd200 || corr_count !== 16'(model_cnt)) begin
      n_fail++;
      $display("[TB] FAIL bp_handoff: got valid=%b ready=%b n=%0d cnt=%0d expected 0/1/200/%0d",
               out_valid, in_ready, out_n, corr_count, model_cnt);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bp_no_accept: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_div2();
    int guard;
    bit seen;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1;
    in_w     = WW'(389848);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_busy: got valid=%b ready=%b expected 0/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_cnt = 0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || corr_count !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_state: got valid=%b ready=%b cnt=%0d expected 0/1/0", out_valid, in_ready, corr_count);
    end
    n_cmp++;
    if (out_n !== 8'd0 || out_corrected !== 1'b0 || out_uncorr !== 1'b0 || out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_outputs: got n=%0d c=%b u=%b o=%b expected all 0", out_n, out_corrected, out_uncorr, out_overflow);
    end
    seen = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_discard: got out_valid=1 after reset expected 0");
    end
  endtask

  task automatic test_back_to_back();
    int  nval, kind, sh, w, cycles, stall, results;
    int  exp_n, exp_c, exp_u, exp_o;
    bit  ok, done;
    results = 0;
    for (int t = 0; t < 100; t++) begin
      nval = int'($urandom_range(0, 270));
      kind = int'($urandom_range(0, 3));
      sh   = int'($urandom_range(0, 18));
      w    = A * nval;
      if (kind == 1) w = w + (1 << sh);
      else if (kind == 2) w = w - (1 << sh);
      else if (kind == 3) w = int'($urandom_range(0, 524287));
      if (w < 0 || w > 524287) w = A * nval;
      model(longint'(w), exp_n, exp_c, exp_u, exp_o);
      if (exp_c != 0) model_cnt++;
      send_word(w, cycles, ok);
      n_cmp++;
      if (!ok || cycles != ((exp_c != 0) ? 41 : 21)) begin
        n_fail++;
        $display("[TB] FAIL b2b_latency w=%0d: got %0d cycles expected %0d", w, cycles, (exp_c != 0) ? 41 : 21);
      end
      stall = 0;
      done  = 1'b0;
      while (!done) begin
        if (stall >= 8 || $urandom_range(0, 1) == 1) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_n !== NW'(exp_n) || out_corrected !== exp_c[0] ||
              out_uncorr !== exp_u[0] || out_overflow !== exp_o[0]) begin
            n_fail++;
            $display("[TB] FAIL b2b_result w=%0d: got v=%b n=%0d c=%b u=%b o=%b expected v=1 n=%0d c=%0d u=%0d o=%0d",
                     w, out_valid, out_n, out_corrected, out_uncorr, out_overflow, exp_n, exp_c, exp_u, exp_o);
          end
          n_cmp++;
          if (corr_count !== 16'(model_cnt)) begin
            n_fail++;
            $display("[TB] FAIL b2b_count w=%0d: got %0d expected %0d", w, corr_count, model_cnt);
          end
          out_ready = 1'b1;
          @(posedge clk); #1;
          out_ready = 1'b0;
          results++;
          n_cmp++;
          if (out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_drop w=%0d: got out_valid=%b expected 0", w, out_valid);
          end
          done = 1'b1;
        end else begin
          @(posedge clk); #1;
          stall++;
          n_cmp++;
          if (out_valid !== 1'b1 || out_n !== NW'(exp_n)) begin
            n_fail++;
            $display("[TB] FAIL b2b_hold w=%0d: got v=%b n=%0d expected v=1 n=%0d", w, out_valid, out_n, exp_n);
          end
        end
      end
    end
    n_cmp++;
    if (results != 100) begin
      n_fail++;
      $display("[TB] FAIL b2b_results: got %0d expected 100", results);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_w      = '0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_div2();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
